// File: rtl/cnn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cnn_seq_ctrl
//   Phase sequencer for the CNN datapath. It counts input beats on the
//   in_valid stream and decodes each beat into write strobes and addresses for
//   the image, kernel and weight buffers. It latches Opt on the first beat,
//   then times a fixed-length compute phase followed by a short output phase.
//   The datapath holds only storage and arithmetic; every phase decision is
//   made here.
//
// Handshake: in_valid is a one-way valid with no ready. A beat is accepted
//   whenever in_valid=1 in IDLE (beat 0) or LOAD. A low in_valid in LOAD stalls
//   the beat counter. in_valid in COMPUTE or OUTPUT is ignored.
//
// Optional build macro: CNN_SEQ_PROTO_CHECK_EN
//   When defined, adds a sticky proto_err output that flags a gap mid-load or
//   a beat offered during COMPUTE/OUTPUT. Sequencing is unaffected.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous active-high reset
//   in_valid   in   input beat valid
//   opt_in     in   Opt bit, sampled on beat 0 only
//   img_we     out  image buffer write strobe       (combinational)
//   img_addr   out  image buffer address            (combinational)
//   ker_we     out  kernel buffer write strobe      (combinational)
//   ker_addr   out  kernel buffer address           (combinational)
//   w_we       out  weight buffer write strobe      (combinational)
//   w_addr     out  weight buffer address           (combinational)
//   opt_q      out  Opt latched for the pattern     (registered)
//   conv_en    out  compute enable                  (registered)
//   conv_step  out  compute step 0..COMP_CYC-1      (registered)
//   out_sel    out  output beat index 0..OUT_LEN-1  (registered)
//   out_valid  out  output beat valid               (registered)
//   busy       out  high in every state but IDLE    (registered)
//   proto_err  out  sticky protocol error (only with CNN_SEQ_PROTO_CHECK_EN)
// -----------------------------------------------------------------------------
module cnn_seq_ctrl #(
    parameter int IMG_LEN  = 75,
    parameter int KER_LEN  = 12,
    parameter int W_LEN    = 24,
    parameter int COMP_CYC = 40,
    parameter int OUT_LEN  = 3,
    localparam int IW = (IMG_LEN  > 1) ? $clog2(IMG_LEN)  : 1,
    localparam int KW = (KER_LEN  > 1) ? $clog2(KER_LEN)  : 1,
    localparam int WW = (W_LEN    > 1) ? $clog2(W_LEN)    : 1,
    localparam int CW = (COMP_CYC > 1) ? $clog2(COMP_CYC) : 1,
    localparam int OW = (OUT_LEN  > 1) ? $clog2(OUT_LEN)  : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          opt_in,
    output logic          img_we,
    output logic [IW-1:0] img_addr,
    output logic          ker_we,
    output logic [KW-1:0] ker_addr,
    output logic          w_we,
    output logic [WW-1:0] w_addr,
    output logic          opt_q,
    output logic          conv_en,
    output logic [CW-1:0] conv_step,
    output logic [OW-1:0] out_sel,
    output logic          out_valid,
    output logic          busy
`ifdef CNN_SEQ_PROTO_CHECK_EN
    ,
    output logic          proto_err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_COMPUTE = 2'd2,
        S_OUTPUT  = 2'd3
    } state_t;

    // One extra bit on the limits so a length equal to 2**IW still compares correctly.
    localparam logic [IW:0]   IMG_LIM   = (IW+1)'(IMG_LEN);
    localparam logic [IW:0]   KER_LIM   = (IW+1)'(KER_LEN);
    localparam logic [IW:0]   W_LIM     = (IW+1)'(W_LEN);
    localparam logic [IW-1:0] IMG_LAST  = IW'(IMG_LEN - 1);
    localparam logic [CW-1:0] STEP_LAST = CW'(COMP_CYC - 1);
    localparam logic [OW-1:0] SEL_LAST  = OW'(OUT_LEN - 1);

    state_t        r_state;
    logic [IW-1:0] r_beat_cnt;
    logic          r_opt_q;
    logic          r_conv_en;
    logic [CW-1:0] r_conv_step;
    logic [OW-1:0] r_out_sel;
    logic          r_out_valid;
    logic          r_busy;

    logic [IW-1:0] w_beat;
    logic          w_loading;

    // Beat index: IDLE always presents beat 0, LOAD presents the running count.
    assign w_beat    = (r_state == S_LOAD) ? r_beat_cnt : '0;
    assign w_loading = in_valid && ((r_state == S_IDLE) || (r_state == S_LOAD));

    assign img_we   = w_loading && ({1'b0, w_beat} < IMG_LIM);
    assign ker_we   = w_loading && ({1'b0, w_beat} < KER_LIM);
    assign w_we     = w_loading && ({1'b0, w_beat} < W_LIM);
    assign img_addr = img_we ? w_beat          : '0;
    assign ker_addr = ker_we ? w_beat[KW-1:0]  : '0;
    assign w_addr   = w_we   ? w_beat[WW-1:0]  : '0;

    assign opt_q     = r_opt_q;
    assign conv_en   = r_conv_en;
    assign conv_step = r_conv_step;
    assign out_sel   = r_out_sel;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_beat_cnt  <= '0;
            r_opt_q     <= 1'b0;
            r_conv_en   <= 1'b0;
            r_conv_step <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_opt_q <= opt_in;
                        r_busy  <= 1'b1;
                        // A one-beat image finishes loading on beat 0 itself.
                        if (IMG_LEN == 1) begin
                            r_state     <= S_COMPUTE;
                            r_conv_en   <= 1'b1;
                            r_conv_step <= '0;
                        end else begin
                            r_state    <= S_LOAD;
                            r_beat_cnt <= IW'(1);
                        end
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        if (r_beat_cnt == IMG_LAST) begin
                            r_state     <= S_COMPUTE;
                            r_beat_cnt  <= '0;
                            r_conv_en   <= 1'b1;
                            r_conv_step <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + 1'b1;
                        end
                    end
                end
                S_COMPUTE: begin
                    if (r_conv_step == STEP_LAST) begin
                        r_state     <= S_OUTPUT;
                        r_conv_en   <= 1'b0;
                        r_conv_step <= '0;
                        r_out_valid <= 1'b1;
                        r_out_sel   <= '0;
                    end else begin
                        r_conv_step <= r_conv_step + 1'b1;
                    end
                end
                S_OUTPUT: begin
                    if (r_out_sel == SEL_LAST) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_out_sel   <= '0;
                        r_busy      <= 1'b0;
                    end else begin
                        r_out_sel <= r_out_sel + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef CNN_SEQ_PROTO_CHECK_EN
    logic r_proto_err;
    assign proto_err = r_proto_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_proto_err <= 1'b0;
        end else if (((r_state == S_LOAD) && !in_valid) ||
                     (((r_state == S_COMPUTE) || (r_state == S_OUTPUT)) && in_valid)) begin
            r_proto_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/cnn_seq_ctrl.md
Name: cnn_seq_ctrl

Overview:
Top-level sequencer for the CNN datapath. It counts input beats on the in_valid stream and decodes them into write strobes and addresses for the image, kernel and weight buffers. It latches Opt, then times the fixed-length compute phase and drives out_valid and the output-select index. It sits beside the CNN datapath and owns every phase decision; the datapath holds only storage and arithmetic.

Parameters:
IMG_LEN, 75, image beats per pattern (3 channels x 5x5)
KER_LEN, 12, kernel beats per pattern (ch1/ch2 share a beat); must be <= IMG_LEN
W_LEN, 24, FC weight beats per pattern; must be <= IMG_LEN
COMP_CYC, 40, compute-phase length in cycles; must be >= 1
OUT_LEN, 3, output beats per pattern; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
in_valid  in  1  input beat valid from pattern/host
opt_in  in  1  Opt bit; sampled on the first beat only
img_we  out  1  image buffer write strobe
img_addr  out  7  image buffer address (clog2 IMG_LEN)
ker_we  out  1  kernel buffer write strobe
ker_addr  out  4  kernel buffer address (clog2 KER_LEN)
w_we  out  1  weight buffer write strobe
w_addr  out  5  weight buffer address (clog2 W_LEN)
opt_q  out  1  latched Opt for the whole pattern
conv_en  out  1  datapath compute enable
conv_step  out  6  compute step index, 0..COMP_CYC-1
out_sel  out  2  output beat index, 0..OUT_LEN-1
out_valid  out  1  output beat valid
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, LOAD, COMPUTE, OUTPUT. Reset (async, rst=1) forces IDLE, all counters to 0, every output to 0, including opt_q.
- IDLE: in_valid=1 is beat 0. opt_q <= opt_in. beat_cnt <= 1. Next state is LOAD. Write strobes for beat 0 are asserted in this same cycle.
- Write strobes are combinational from in_valid, state and beat index b (b = 0 in IDLE, beat_cnt in LOAD):
  - img_we = in_valid & (b < IMG_LEN), img_addr = b
  - ker_we = in_valid & (b < KER_LEN), ker_addr = b
  - w_we = in_valid & (b < W_LEN), w_addr = b
  - Addresses read 0 when the matching strobe is low.
- LOAD: beat_cnt increments only on in_valid=1. An in_valid=0 gap stalls the counter and all strobes stay low. The beat with b = IMG_LEN-1 moves the FSM to COMPUTE and clears beat_cnt.
- COMPUTE: conv_en=1 and conv_step counts 0..COMP_CYC-1, one per cycle. After step COMP_CYC-1 the FSM moves to OUTPUT and conv_step clears.
- OUTPUT: out_valid=1 and out_sel counts 0..OUT_LEN-1, one per cycle. After the last beat the FSM moves to IDLE and out_sel clears.
- Timing: the last input beat is at cycle T. conv_en is high T+1..T+COMP_CYC. out_valid is high T+COMP_CYC+1..T+COMP_CYC+OUT_LEN.
- in_valid during COMPUTE or OUTPUT is ignored: no strobes, no state change. Changes to opt_in after beat 0 are ignored.
- Back-to-back: in_valid in the first cycle after returning to IDLE starts a new pattern, so there is zero idle gap.
- Reset asserted mid-pattern aborts at once; no partial out_valid follows.
- Outputs conv_en, conv_step, out_valid, out_sel, opt_q and busy are registered; only the write strobes and addresses are combinational.

Optional Feature:
CNN_SEQ_PROTO_CHECK_EN:
- Defined: adds output proto_err (1 bit, sticky, cleared only by rst). It sets when either of these occurs:
  - in_valid=0 in LOAD (a gap mid-load);
  - in_valid=1 in COMPUTE or OUTPUT.
  Sequencing is unchanged by the check.
- Undefined: no proto_err port and no check logic; gaps stall silently as described in Behaviour.

Test Plan:
- Reset, then 75 contiguous beats from cycle 0 with opt_in=1 on beat 0 -> img_we cycles 0..74 with img_addr=cycle; ker_we 0..11; w_we 0..23; opt_q=1 from cycle 1; conv_en 75..114; out_valid 115..117 with out_sel 0,1,2; busy falls at 118.
- Same stream with in_valid low at cycles 10..12 -> beat_cnt holds, img_addr resumes at 10 on cycle 13; out_valid shifts to 118..120; with the macro defined, proto_err=1 from cycle 11.
- opt_in=0 on beat 0 then 1 on every later beat -> opt_q stays 0 for the whole pattern.
- in_valid=1 throughout COMPUTE and OUTPUT -> no write strobes, timing unchanged; with the macro defined, proto_err=1.
- Two patterns back-to-back, second beat 0 at cycle 118 -> second out_valid at 233..235; second opt_q is taken from the second beat 0.
- rst pulsed at cycle 90 (mid-COMPUTE) -> all outputs 0 immediately, no out_valid afterward; a fresh pattern then completes normally.
